fifo_enq_arbiter: RTL and testbench
===================================

Name: fifo_enq_arbiter

Overview:
Round-robin arbiter that shares the enqueue side of one single-entry FIFO (fifo enq/deq/first guarded interface) among NREQ requesters.
- Requesters raise intent on req_valid. The arbiter returns a per-port __RDY grant and forwards the granted enq (__ENA plus 32-bit value) to the FIFO.
- Optional burst hold lets one winner keep priority for up to MAX_BURST consecutive enqueues.
- A sticky protocol-error flag catches enqueues on ungranted ports.
- Sits between producer rules and the shared FIFO instance.

Parameters:
NREQ, 4, number of requesters (2..8).
DWIDTH, 32, enqueue payload width.
MAX_BURST, 1, consecutive accepted enqueues the current winner may make before priority rotates (1 = pure round-robin).

Ports:
CLK  input  1  clock.
nRST  input  1  reset, synchronous, active-low.
req_valid  input  NREQ  bit i: requester i wants to enqueue this cycle.
req_enq__ENA  input  NREQ  bit i: requester i enqueues; legal only while its req_enq__RDY bit is 1.
req_enq_v  input  NREQ*DWIDTH  payloads; slice i is [i*DWIDTH +: DWIDTH].
req_enq__RDY  output  NREQ  one-hot-or-zero grant.
fifo_enq__ENA  output  1  enqueue strobe to the shared FIFO.
fifo_enq_v  output  DWIDTH  payload to the FIFO.
fifo_enq__RDY  input  1  FIFO can accept (FIFO not full).
grant_id  output  clog2(NREQ)  index of current winner; valid when grant_valid=1.
grant_valid  output  1  some req_valid bit is set.
protocol_err  output  1  sticky; set by an ENA on an ungranted port.

Behaviour:
- State:
  - rr_ptr: clog2(NREQ) bits, the highest-priority index.
  - burst_cnt: clog2(MAX_BURST+1) bits.
  - protocol_err: 1 bit.
- Reset (nRST=0 at posedge CLK): rr_ptr=0, burst_cnt=0, protocol_err=0. Reset overrides any same-cycle enqueue.
- All outputs except protocol_err are combinational from state and inputs. No added latency: the FIFO sees the enq in the same cycle as requester ENA.
- Winner selection: scan indices rr_ptr, rr_ptr+1, … mod NREQ. The winner is the first index with req_valid set. grant_valid = |req_valid.
- req_enq__RDY[w] = fifo_enq__RDY & grant_valid for winner w. All other RDY bits are 0. With no valid requests, all RDY bits are 0.
- Accepted enqueue: acc = req_enq__ENA[w] & req_enq__RDY[w].
  - fifo_enq__ENA = acc.
  - fifo_enq_v = payload slice w. It is driven by slice w even when acc=0.
- Update on acc (not in reset):
  - If burst_cnt+1 < MAX_BURST: rr_ptr <= w, burst_cnt <= burst_cnt+1.
  - Otherwise: rr_ptr <= (w+1) mod NREQ, burst_cnt <= 0.
  - Wrap from NREQ-1 goes to 0.
- No acc: rr_ptr holds. burst_cnt holds only if req_valid[rr_ptr] stays 1 and rr_ptr equals the last winner. Otherwise burst_cnt <= 0, so a burst is forfeited when the holder drops valid.
- FIFO full (fifo_enq__RDY=0): all RDY bits are 0 and state holds. grant_id still reports the pending winner.
- Illegal ENA: any req_enq__ENA[i] with req_enq__RDY[i]=0 sets protocol_err=1 until reset. That ENA is never forwarded. A legal acc in the same cycle still proceeds.
- Simultaneous valid on all ports: grants rotate fairly, each port at most MAX_BURST consecutive enqueues.
- The arbiter does not drive the FIFO's deq/first side.

Decomposition:
- Shared package: NREQ/DWIDTH defaults, clog2 function, grant-index typedef.
- Natural sub-module: rr_priority_pick (rotating priority encoder: req_valid, rr_ptr -> winner, any).
- State registers and muxing stay in fifo_enq_arbiter.

Test Plan:
- Reset: hold nRST=0 with req_valid=4'b1111 and fifo_enq__RDY=1 -> after release rr_ptr=0, grant_id=0, req_enq__RDY=4'b0001, protocol_err=0.
- Round-robin: all valid, each granted port ENAs with v=0xA0+i, FIFO drained every cycle -> FIFO receives 0xA0,0xA1,0xA2,0xA3,0xA0; grant_id sequence 0,1,2,3,0.
- FIFO full: fifo_enq__RDY=0 for 3 cycles with req_valid=4'b0110 -> req_enq__RDY=0 and fifo_enq__ENA=0 throughout, grant_id=1 held; on RDY=1, port 1 is granted first.
- Burst: MAX_BURST=2, all valid -> accepted order 0,0,1,1,2,2,3,3. Port 0 drops valid after its first enq -> burst_cnt clears and the next grant goes to port 1.
- Protocol error: req_enq__ENA=4'b0100 while the grant is on port 0 -> fifo_enq__ENA=0, protocol_err=1 from the next cycle and held until nRST=0.
- Reset mid-operation: nRST=0 in the same cycle as an accepted enq from port 2 -> rr_ptr=0 and burst_cnt=0 next cycle.

Source files
------------

// File: rtl/fifo_enq_arbiter_pkg.sv
// fifo_enq_arbiter_pkg: shared defaults, clog2 helper and grant-index type for the enqueue arbiter
package fifo_enq_arbiter_pkg;
  localparam int NREQ_DEF = 4;
  localparam int DWIDTH_DEF = 32;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
  typedef logic [clog2(NREQ_DEF)-1:0] gid_t;
endpackage

// File: rtl/fifo_enq_arbiter_rr_priority_pick.sv
// rr_priority_pick: rotating priority encoder, first set request at or after ptr_i (mod N)
module rr_priority_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] win_o,
  output logic          any_o
);
  logic [IW-1:0] idx;
  always_comb begin
    win_o = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_i) + k) % N);
      if (req_i[idx]) win_o = idx;
    end
  end
  assign any_o = |req_i;
endmodule

// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter: round-robin share of one FIFO enqueue port among NREQ producers,
// with optional burst hold and a sticky flag for enqueues on ungranted ports
module fifo_enq_arbiter import fifo_enq_arbiter_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int MAX_BURST = 1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_enq__ENA,
  input  logic [NREQ*DWIDTH-1:0]   req_enq_v,
  output logic [NREQ-1:0]          req_enq__RDY,
  output logic                     fifo_enq__ENA,
  output logic [DWIDTH-1:0]        fifo_enq_v,
  input  logic                     fifo_enq__RDY,
  output logic [clog2(NREQ)-1:0]   grant_id,
  output logic                     grant_valid,
  output logic                     protocol_err
);
  localparam int IW = clog2(NREQ);
  localparam int BW = clog2(MAX_BURST + 1);
  logic [IW-1:0] rr_q, rr_d, win, wrap;
  logic [BW-1:0] bc_q, bc_d;
  logic err_q, err_d, any, acc, hold;
  logic [DWIDTH-1:0] pay [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_pay
    assign pay[g] = req_enq_v[g*DWIDTH +: DWIDTH];
  end
  rr_priority_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req_i(req_valid),
    .ptr_i(rr_q),
    .win_o(win),
    .any_o(any)
  );
  always_comb begin
    grant_id = win;
    grant_valid = any;
    req_enq__RDY = '0;
    req_enq__RDY[win] = fifo_enq__RDY & any;
    acc = req_enq__ENA[win] & req_enq__RDY[win];
    fifo_enq__ENA = acc;
    fifo_enq_v = pay[win];
    wrap = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
    hold = (int'(bc_q) + 1 < MAX_BURST);
    rr_d = acc ? (hold ? win : wrap) : rr_q;
    // a burst is forfeited once the holder drops valid, but a full FIFO freezes everything
    bc_d = acc ? (hold ? bc_q + 1'b1 : '0) : (fifo_enq__RDY && !req_valid[rr_q]) ? '0 : bc_q;
    err_d = err_q | (|(req_enq__ENA & ~req_enq__RDY));
    protocol_err = err_q;
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rr_q <= '0;
      bc_q <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      bc_q <= bc_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// tb_fifo_enq_arbiter: two arbiters (MAX_BURST=1 and 2) against a behavioural model plus directed literals
module tb_fifo_enq_arbiter;
  logic CLK = 1'b0, nRST = 1'b0, f = 1'b1;
  logic [3:0] v = 4'hf;
  logic [3:0] e [2];
  logic [127:0] pv = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  logic [3:0] rdy [2];
  logic fe [2], gv [2], perr [2];
  logic [31:0] fv [2];
  logic [1:0] gid [2];
  int checks = 0, failures = 0;
  int m_rr [2], m_bc [2];
  logic m_err [2];
  bit m_ok = 0;
  int lg_id [2][$];
  int lg_v [2][$];
  localparam int MB [2] = '{1, 2};

  always #5 CLK = ~CLK;

  fifo_enq_arbiter #(.NREQ(4), .DWIDTH(32), .MAX_BURST(1)) u0 (
    .CLK(CLK), .nRST(nRST), .req_valid(v), .req_enq__ENA(e[0]), .req_enq_v(pv),
    .req_enq__RDY(rdy[0]), .fifo_enq__ENA(fe[0]), .fifo_enq_v(fv[0]), .fifo_enq__RDY(f),
    .grant_id(gid[0]), .grant_valid(gv[0]), .protocol_err(perr[0]));
  fifo_enq_arbiter #(.NREQ(4), .DWIDTH(32), .MAX_BURST(2)) u1 (
    .CLK(CLK), .nRST(nRST), .req_valid(v), .req_enq__ENA(e[1]), .req_enq_v(pv),
    .req_enq__RDY(rdy[1]), .fifo_enq__ENA(fe[1]), .fifo_enq_v(fv[1]), .fifo_enq__RDY(f),
    .grant_id(gid[1]), .grant_valid(gv[1]), .protocol_err(perr[1]));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, a, x, $time);
    end
  endtask

  function automatic int mwin(input int rr, input logic [3:0] vv);
    for (int k = 0; k < 4; k++) if (vv[(rr + k) % 4]) return (rr + k) % 4;
    return 0;
  endfunction

  // reference: scan for the winner, then apply the burst/rotation rules
  always @(posedge CLK) begin
    int w, nrr, nbc;
    logic [3:0] grant;
    logic acc;
    for (int d = 0; d < 2; d++) begin
      w = mwin(m_rr[d], v);
      grant = (f && v != 0) ? (4'b1 << w) : 4'b0;
      acc = (e[d] & grant) != 0;
      nrr = m_rr[d];
      nbc = m_bc[d];
      if (acc) begin
        if (m_bc[d] + 1 < MB[d]) begin nrr = w; nbc = m_bc[d] + 1; end
        else begin nrr = (w + 1) % 4; nbc = 0; end
      end else if (f && !v[m_rr[d]]) nbc = 0;
      if (!nRST) begin
        m_rr[d] <= 0; m_bc[d] <= 0; m_err[d] <= 1'b0;
      end else begin
        m_rr[d] <= nrr; m_bc[d] <= nbc;
        m_err[d] <= m_err[d] | ((e[d] & ~grant) != 0);
      end
    end
    if (!nRST) m_ok <= 1;
  end

  always @(negedge CLK) begin
    int w;
    logic [3:0] grant;
    if (m_ok) begin
      for (int d = 0; d < 2; d++) begin
        w = mwin(m_rr[d], v);
        grant = (f && v != 0) ? (4'b1 << w) : 4'b0;
        chk($sformatf("rdy%0d", d), 32'(rdy[d]), 32'(grant));
        chk($sformatf("fe%0d", d), 32'(fe[d]), 32'((e[d] & grant) != 0));
        chk($sformatf("gv%0d", d), 32'(gv[d]), 32'(v != 0));
        chk($sformatf("perr%0d", d), 32'(perr[d]), 32'(m_err[d]));
        if (v != 0) begin
          chk($sformatf("gid%0d", d), 32'(gid[d]), 32'(w));
          chk($sformatf("fv%0d", d), fv[d], pv[w*32 +: 32]);
        end
        if (fe[d] === 1'b1) begin
          lg_id[d].push_back(int'(gid[d]));
          lg_v[d].push_back(int'(fv[d]));
        end
      end
    end
  end

  task automatic set(input logic r, input logic [3:0] vv, input logic ff,
                     input logic [3:0] e0, input logic [3:0] e1, input bit a0, input bit a1);
    nRST = r; v = vv; f = ff; e[0] = e0; e[1] = e1;
    #1;
    if (a0) e[0] = rdy[0];
    if (a1) e[1] = rdy[1];
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chkq(input string n, input int q [$], input int x [$]);
    chk({n, "_len"}, q.size(), x.size());
    for (int i = 0; i < x.size() && i < q.size(); i++) chk($sformatf("%s[%0d]", n, i), q[i], x[i]);
  endtask

  initial begin
    e[0] = 4'h0; e[1] = 4'h0;
    set(0, 4'hf, 1, 0, 0, 0, 0);
    repeat (3) tick();
    set(1, 4'hf, 1, 0, 0, 0, 0);
    chk("rst_gid", 32'(gid[0]), 0);
    chk("rst_rdy", 32'(rdy[0]), 32'h1);
    chk("rst_perr", 32'(perr[0]), 0);
    lg_id[0].delete(); lg_v[0].delete(); lg_id[1].delete(); lg_v[1].delete();
    repeat (8) begin set(1, 4'hf, 1, 0, 0, 1, 1); tick(); end
    chkq("rr_v", lg_v[0], '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0, 32'hA1, 32'hA2, 32'hA3});
    chkq("rr_id", lg_id[0], '{0, 1, 2, 3, 0, 1, 2, 3});
    chkq("burst_id", lg_id[1], '{0, 0, 1, 1, 2, 2, 3, 3});
    repeat (3) begin
      set(1, 4'b0110, 0, 0, 0, 1, 1);
      chk("full_rdy", 32'(rdy[0]), 0);
      chk("full_fe", 32'(fe[0]), 0);
      chk("full_gid", 32'(gid[0]), 1);
      tick();
    end
    set(1, 4'b0110, 1, 0, 0, 1, 1);
    chk("unfull_gid", 32'(gid[0]), 1);
    chk("unfull_rdy", 32'(rdy[0]), 32'b0010);
    chk("unfull_fe", 32'(fe[0]), 1);
    tick();
    set(0, 4'b0100, 1, 0, 0, 1, 0);
    chk("rstacc_fe", 32'(fe[0]), 1);
    chk("rstacc_gid", 32'(gid[0]), 2);
    tick();
    lg_id[1].delete();
    set(1, 4'hf, 1, 0, 0, 0, 1);
    chk("rstmid_gid0", 32'(gid[0]), 0);
    chk("rstmid_gid1", 32'(gid[1]), 0);
    tick();
    set(1, 4'b1110, 1, 0, 0, 0, 0);
    chk("drop_gid1", 32'(gid[1]), 1);
    tick();
    repeat (3) begin set(1, 4'hf, 1, 0, 0, 0, 1); tick(); end
    chkq("forfeit_id", lg_id[1], '{0, 0, 0, 1});
    set(1, 4'hf, 1, 4'b0100, 0, 0, 0);
    chk("perr_fe", 32'(fe[0]), 0);
    chk("perr_pre", 32'(perr[0]), 0);
    tick();
    set(1, 4'hf, 1, 4'b0101, 0, 0, 0);
    chk("perr_set", 32'(perr[0]), 1);
    chk("perr_legal_fe", 32'(fe[0]), 1);
    chk("perr_legal_v", fv[0], 32'hA0);
    tick();
    set(1, 4'h0, 1, 0, 0, 0, 0);
    repeat (3) tick();
    chk("perr_hold", 32'(perr[0]), 1);
    set(0, 4'h0, 1, 0, 0, 0, 0);
    tick();
    set(1, 4'h0, 1, 0, 0, 0, 0);
    chk("perr_clr", 32'(perr[0]), 0);
    tick();
    repeat (400) begin
      pv = {$urandom, $urandom, $urandom, $urandom};
      set(logic'($urandom_range(0, 49) != 0), 4'($urandom), logic'($urandom_range(0, 3) != 0),
          4'($urandom), 4'($urandom), $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8);
      tick();
    end
    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
